// File: rtl/l2_axi_serdes_pkg.sv
// AXI bus/L2 struct types plus serdes state, register image and beat geometry helper.
// Geometry: line 256b / bus 64b -> 4 beats; beat size 3 (8 bytes).
package types_amba_pkg;
    localparam int CFG_SYSBUS_ADDR_BITS  = 48;
    localparam int CFG_SYSBUS_DATA_BITS  = 64;
    localparam int CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;
    localparam int CFG_SYSBUS_ID_BITS    = 5;
    localparam int CFG_SYSBUS_USER_BITS  = 1;

    localparam logic [1:0] AXI_BURST_INCR = 2'd1;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'd0;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
    localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

    typedef struct packed {
        logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
        logic [7:0]                      len;
        logic [2:0]                      size;
        logic [1:0]                      burst;
        logic                            lock;
        logic [3:0]                      cache;
        logic [2:0]                      prot;
        logic [3:0]                      qos;
        logic [3:0]                      region;
    } axi4_metadata_type;

    typedef struct packed {
        logic                              aw_valid;
        axi4_metadata_type                 aw_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]     aw_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]   aw_user;
        logic                              w_valid;
        logic [CFG_SYSBUS_DATA_BITS-1:0]   w_data;
        logic                              w_last;
        logic [CFG_SYSBUS_DATA_BYTES-1:0]  w_strb;
        logic [CFG_SYSBUS_USER_BITS-1:0]   w_user;
        logic                              b_ready;
        logic                              ar_valid;
        axi4_metadata_type                 ar_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]     ar_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]   ar_user;
        logic                              r_ready;
    } axi4_master_out_type;

    typedef struct packed {
        logic                              aw_ready;
        logic                              w_ready;
        logic                              b_valid;
        logic [1:0]                        b_resp;
        logic [CFG_SYSBUS_ID_BITS-1:0]     b_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]   b_user;
        logic                              ar_ready;
        logic                              r_valid;
        logic [1:0]                        r_resp;
        logic [CFG_SYSBUS_DATA_BITS-1:0]   r_data;
        logic                              r_last;
        logic [CFG_SYSBUS_ID_BITS-1:0]     r_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]   r_user;
    } axi4_master_in_type;
endpackage

package types_river_pkg;
    import types_amba_pkg::*;
    localparam int L1CACHE_LINE_BITS      = 256;
    localparam int L1CACHE_BYTES_PER_LINE = L1CACHE_LINE_BITS / 8;

    typedef struct packed {
        logic                                aw_valid;
        axi4_metadata_type                   aw_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]       aw_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]     aw_user;
        logic                                w_valid;
        logic [L1CACHE_LINE_BITS-1:0]        w_data;
        logic                                w_last;
        logic [L1CACHE_BYTES_PER_LINE-1:0]   w_strb;
        logic [CFG_SYSBUS_USER_BITS-1:0]     w_user;
        logic                                b_ready;
        logic                                ar_valid;
        axi4_metadata_type                   ar_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]       ar_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]     ar_user;
        logic                                r_ready;
    } axi4_l2_out_type;

    typedef struct packed {
        logic                                aw_ready;
        logic                                w_ready;
        logic                                b_valid;
        logic [1:0]                          b_resp;
        logic [CFG_SYSBUS_ID_BITS-1:0]       b_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]     b_user;
        logic                                ar_ready;
        logic                                r_valid;
        logic [1:0]                          r_resp;
        logic [L1CACHE_LINE_BITS-1:0]        r_data;
        logic                                r_last;
        logic [CFG_SYSBUS_ID_BITS-1:0]       r_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]     r_user;
    } axi4_l2_in_type;
endpackage

package l2_axi_serdes_pkg;
    import types_amba_pkg::*;
    import types_river_pkg::*;

    localparam int BEATS     = L1CACHE_LINE_BITS / CFG_SYSBUS_DATA_BITS;
    localparam int BEAT_SIZE = $clog2(CFG_SYSBUS_DATA_BYTES);
    localparam int LINE_SIZE = $clog2(L1CACHE_BYTES_PER_LINE);
    localparam int CNT_W     = $clog2(BEATS) + 1;

    typedef enum logic [2:0] {
        idle, st_ar, st_r, st_l2_r, st_aw, st_w, st_b, st_l2_b
    } l2_axi_serdes_state_t;

    typedef struct packed {
        l2_axi_serdes_state_t              state;
        logic [CFG_SYSBUS_ADDR_BITS-1:0]   addr;
        logic [2:0]                        size;
        logic [7:0]                        len;
        logic [CFG_SYSBUS_ID_BITS-1:0]     id;
        logic [CFG_SYSBUS_USER_BITS-1:0]   user;
        logic [2:0]                        prot;
        logic                              lock;
        logic [L1CACHE_LINE_BITS-1:0]      line;
        logic [L1CACHE_BYTES_PER_LINE-1:0] wstrb;
        logic [1:0]                        resp;
        logic [CNT_W-1:0]                  cnt;
    } l2_axi_serdes_registers;

    localparam l2_axi_serdes_registers l2_axi_serdes_r_reset = '0;

    // Returns {len, beat size}: wider-than-bus requests become a burst of full-width beats.
    function automatic logic [10:0] beat_geom(input logic [2:0] req_size);
        logic [10:0] g;
        g = {8'd0, req_size};
        if (req_size > 3'(BEAT_SIZE)) begin
            g = {8'((1 << (req_size - 3'(BEAT_SIZE))) - 1), 3'(BEAT_SIZE)};
        end
        return g;
    endfunction
endpackage

// File: rtl/l2_axi_serdes.sv
// Line-wide L2 AXI request <-> INCR burst of bus-wide beats; one transaction in flight.
// Optional error counter port o_err_cnt under L2_AXI_SERDES_ERRCNT_EN.
module l2_axi_serdes
    import types_amba_pkg::*;
    import types_river_pkg::*;
    import l2_axi_serdes_pkg::*;
#(
    parameter int LINE_BITS = L1CACHE_LINE_BITS,
    parameter int BUS_BITS  = CFG_SYSBUS_DATA_BITS
) (
    input  logic                i_clk,
    input  logic                i_nrst,
    input  axi4_l2_out_type     i_l2o,
    output axi4_l2_in_type      o_l2i,
    input  axi4_master_in_type  i_msti,
`ifdef L2_AXI_SERDES_ERRCNT_EN
    output logic [15:0]         o_err_cnt,
`endif
    output axi4_master_out_type o_msto
);
    localparam int IDX_W = $clog2(LINE_BITS / BUS_BITS);

    l2_axi_serdes_registers r_q, r_d;
    axi4_metadata_type      meta;
    logic [IDX_W-1:0]       widx;
    logic                   unused_inputs;

    assign unused_inputs = ^{i_l2o, i_msti};

    always_comb begin
        meta       = '0;
        meta.addr  = r_q.addr;
        meta.len   = r_q.len;
        meta.size  = r_q.size;
        meta.burst = AXI_BURST_INCR;
        meta.lock  = r_q.lock;
        meta.prot  = r_q.prot;
    end

    // A single-beat request picks its slice by address; a burst walks the slices in order.
    assign widx = (r_q.len == 8'd0) ? r_q.addr[LINE_SIZE-1:BEAT_SIZE] : r_q.cnt[IDX_W-1:0];

    always_comb begin
        r_d    = r_q;
        o_l2i  = '0;
        o_msto = '0;
        case (r_q.state)
            idle: begin
                if (i_l2o.aw_valid) begin
                    o_l2i.aw_ready       = 1'b1;
                    o_l2i.w_ready        = 1'b1;
                    {r_d.len, r_d.size}  = beat_geom(i_l2o.aw_bits.size);
                    r_d.addr             = i_l2o.aw_bits.addr;
                    r_d.id               = i_l2o.aw_id;
                    r_d.user             = i_l2o.aw_user;
                    r_d.prot             = i_l2o.aw_bits.prot;
                    r_d.lock             = i_l2o.aw_bits.lock;
                    r_d.line             = i_l2o.w_data;
                    r_d.wstrb            = i_l2o.w_strb;
                    r_d.resp             = AXI_RESP_OKAY;
                    r_d.state            = st_aw;
                end else if (i_l2o.ar_valid) begin
                    o_l2i.ar_ready       = 1'b1;
                    {r_d.len, r_d.size}  = beat_geom(i_l2o.ar_bits.size);
                    r_d.addr             = i_l2o.ar_bits.addr;
                    r_d.id               = i_l2o.ar_id;
                    r_d.user             = i_l2o.ar_user;
                    r_d.prot             = i_l2o.ar_bits.prot;
                    r_d.lock             = i_l2o.ar_bits.lock;
                    r_d.resp             = AXI_RESP_OKAY;
                    r_d.state            = st_ar;
                end
            end
            st_ar: begin
                o_msto.ar_valid = 1'b1;
                o_msto.ar_bits  = meta;
                o_msto.ar_id    = r_q.id;
                o_msto.ar_user  = r_q.user;
                if (i_msti.ar_ready) begin
                    r_d.cnt   = '0;
                    r_d.state = st_r;
                end
            end
            st_r: begin
                o_msto.r_ready = 1'b1;
                if (i_msti.r_valid) begin
                    if (r_q.len == 8'd0) begin
                        r_d.line = {BEATS{i_msti.r_data}};
                    end else begin
                        r_d.line[r_q.cnt[IDX_W-1:0]*BUS_BITS +: BUS_BITS] = i_msti.r_data;
                    end
                    // Only the first error is reported; later beats cannot mask it.
                    if (r_q.resp == AXI_RESP_OKAY) begin
                        r_d.resp = i_msti.r_resp;
                    end
                    r_d.cnt = r_q.cnt + 1'b1;
                    if (i_msti.r_last || (8'(r_q.cnt) == r_q.len)) begin
                        r_d.state = st_l2_r;
                    end
                end
            end
            st_l2_r: begin
                o_l2i.r_valid = 1'b1;
                o_l2i.r_last  = 1'b1;
                o_l2i.r_data  = r_q.line;
                o_l2i.r_resp  = r_q.resp;
                o_l2i.r_id    = r_q.id;
                o_l2i.r_user  = r_q.user;
                if (i_l2o.r_ready) begin
                    r_d.state = idle;
                end
            end
            st_aw: begin
                o_msto.aw_valid = 1'b1;
                o_msto.aw_bits  = meta;
                o_msto.aw_id    = r_q.id;
                o_msto.aw_user  = r_q.user;
                if (i_msti.aw_ready) begin
                    r_d.cnt   = '0;
                    r_d.state = st_w;
                end
            end
            st_w: begin
                o_msto.w_valid = 1'b1;
                o_msto.w_data  = r_q.line[widx*BUS_BITS +: BUS_BITS];
                o_msto.w_strb  = r_q.wstrb[widx*(BUS_BITS/8) +: BUS_BITS/8];
                o_msto.w_last  = (8'(r_q.cnt) == r_q.len);
                o_msto.w_user  = r_q.user;
                if (i_msti.w_ready) begin
                    r_d.cnt = r_q.cnt + 1'b1;
                    if (8'(r_q.cnt) == r_q.len) begin
                        r_d.state = st_b;
                    end
                end
            end
            st_b: begin
                o_msto.b_ready = 1'b1;
                if (i_msti.b_valid) begin
                    r_d.resp  = i_msti.b_resp;
                    r_d.state = st_l2_b;
                end
            end
            st_l2_b: begin
                o_l2i.b_valid = 1'b1;
                o_l2i.b_resp  = r_q.resp;
                o_l2i.b_id    = r_q.id;
                o_l2i.b_user  = r_q.user;
                if (i_l2o.b_ready) begin
                    r_d.state = idle;
                end
            end
            default: r_d = l2_axi_serdes_r_reset;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_q <= l2_axi_serdes_r_reset;
        end else begin
            r_q <= r_d;
        end
    end

`ifdef L2_AXI_SERDES_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        txn_err;

    // A transaction counts as complete at its L2-side response handshake.
    always_comb begin
        txn_err = (r_q.resp != AXI_RESP_OKAY) &&
                  (((r_q.state == st_l2_r) && i_l2o.r_ready) ||
                   ((r_q.state == st_l2_b) && i_l2o.b_ready));
        err_cnt_d = err_cnt_q;
        if (txn_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_l2_axi_serdes.sv
// Directed bench for l2_axi_serdes: bursts, narrow transfers, AW priority, error resp, mid-burst reset.
`timescale 1ns/1ps
module tb_l2_axi_serdes;
    import types_amba_pkg::*;
    import types_river_pkg::*;

    logic                clk = 1'b0;
    logic                nrst;
    axi4_l2_out_type     l2o;
    axi4_l2_in_type      l2i;
    axi4_master_in_type  msti;
    axi4_master_out_type msto;
`ifdef L2_AXI_SERDES_ERRCNT_EN
    logic [15:0]         err_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    l2_axi_serdes dut (
        .i_clk     (clk),
        .i_nrst    (nrst),
        .i_l2o     (l2o),
        .o_l2i     (l2i),
        .i_msti    (msti),
`ifdef L2_AXI_SERDES_ERRCNT_EN
        .o_err_cnt (err_cnt),
`endif
        .o_msto    (msto)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait bus slave for a read; lat is the cycle number (accept cycle = 1) of L2 r_valid.
    task automatic bus_read(input logic [255:0] beats, input logic [7:0] resps,
                            input int nbeats, output int lat);
        int k = 0;
        lat = 2;
        for (int c = 0; c < 40; c++) begin
            if (l2i.r_valid) break;
            msti = '0;
            msti.ar_ready = msto.ar_valid;
            if (msto.r_ready && k < nbeats) begin
                msti.r_valid = 1'b1;
                msti.r_data  = beats[k*64 +: 64];
                msti.r_resp  = resps[k*2 +: 2];
                msti.r_last  = (k == nbeats - 1);
            end
            tick();
            if (msti.r_valid) k++;
            lat++;
        end
        msti = '0;
        chk("rd_l2_r_valid", l2i.r_valid, 1'b1);
    endtask

    // Zero-wait bus slave for a write; records every W beat up to four.
    task automatic bus_write(input logic [1:0] bresp, output logic [255:0] wd,
                             output logic [31:0] ws, output logic [3:0] wl, output int nw);
        wd = '0; ws = '0; wl = '0; nw = 0;
        for (int c = 0; c < 40; c++) begin
            if (l2i.b_valid) break;
            msti = '0;
            msti.aw_ready = msto.aw_valid;
            msti.w_ready  = msto.w_valid;
            if (msto.w_valid && nw < 4) begin
                wd[nw*64 +: 64] = msto.w_data;
                ws[nw*8 +: 8]   = msto.w_strb;
                wl[nw]          = msto.w_last;
            end
            if (msto.w_valid) nw++;
            msti.b_valid = msto.b_ready;
            msti.b_resp  = bresp;
            tick();
        end
        msti = '0;
        chk("wr_l2_b_valid", l2i.b_valid, 1'b1);
    endtask

    task automatic l2_r_ack();
        l2o.r_ready = 1'b1;
        tick();
        l2o.r_ready = 1'b0;
    endtask

    task automatic l2_b_ack();
        l2o.b_ready = 1'b1;
        tick();
        l2o.b_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           lat;
        int           nw;
        logic [255:0] wd;
        logic [31:0]  ws;
        logic [3:0]   wl;
        logic [255:0] wline;

        wline = {64'h4040_4040_4040_4040, 64'h3030_3030_3030_3030,
                 64'h2020_2020_2020_2020, 64'h1010_1010_1010_1010};
        l2o  = '0;
        msti = '0;
        nrst = 1'b0;
        tick();
        tick();
        chk("rst_l2i", l2i, '0);
        chk("rst_msto_vr", {msto.ar_valid, msto.aw_valid, msto.w_valid, msto.r_ready, msto.b_ready}, 5'd0);
`ifdef L2_AXI_SERDES_ERRCNT_EN
        chk("rst_err_cnt", err_cnt, 16'd0);
`endif
        nrst = 1'b1;
        tick();

        // 1. Four-beat read, zero wait.
        l2o.ar_valid = 1'b1;
        l2o.ar_bits.addr = 48'h8000_0020;
        l2o.ar_bits.size = 3'd5;
        l2o.ar_id = 5'd3;
        l2o.ar_user = 1'b1;
        #1;
        chk("t1_ar_ready", l2i.ar_ready, 1'b1);
        chk("t1_aw_ready", l2i.aw_ready, 1'b0);
        tick();
        l2o.ar_valid = 1'b0;
        chk("t1_ar_valid", msto.ar_valid, 1'b1);
        chk("t1_ar_len", msto.ar_bits.len, 8'd3);
        chk("t1_ar_size", msto.ar_bits.size, 3'd3);
        chk("t1_ar_addr", msto.ar_bits.addr, 48'h8000_0020);
        chk("t1_ar_burst", msto.ar_bits.burst, 2'd1);
        bus_read({64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 8'h00, 4, lat);
        chk("t1_latency", lat, 7);
        chk("t1_r_data", l2i.r_data, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        chk("t1_r_resp", l2i.r_resp, 2'd0);
        chk("t1_r_last", l2i.r_last, 1'b1);
        chk("t1_r_id", l2i.r_id, 5'd3);
        chk("t1_r_user", l2i.r_user, 1'b1);
        l2_r_ack();
        chk("t1_r_valid_drop", l2i.r_valid, 1'b0);

        // 2. Four-beat write with sparse strobes.
        l2o.aw_valid = 1'b1;
        l2o.w_valid = 1'b1;
        l2o.aw_bits.addr = 48'h8000_0040;
        l2o.aw_bits.size = 3'd5;
        l2o.aw_id = 5'd7;
        l2o.aw_user = 1'b0;
        l2o.w_data = wline;
        l2o.w_strb = 32'hFFFF_00FF;
        #1;
        chk("t2_aw_w_ready", {l2i.aw_ready, l2i.w_ready}, 2'b11);
        tick();
        l2o.aw_valid = 1'b0;
        l2o.w_valid = 1'b0;
        chk("t2_aw_len", msto.aw_bits.len, 8'd3);
        chk("t2_aw_size", msto.aw_bits.size, 3'd3);
        bus_write(2'd0, wd, ws, wl, nw);
        chk("t2_nbeats", nw, 4);
        chk("t2_w_data", wd, wline);
        chk("t2_w_strb", ws, 32'hFFFF_00FF);
        chk("t2_w_last", wl, 4'b1000);
        chk("t2_b_resp", l2i.b_resp, 2'd0);
        chk("t2_b_id", l2i.b_id, 5'd7);
        chk("t2_b_user", l2i.b_user, 1'b0);
        l2_b_ack();

        // 3a. Narrow read replicates one beat across the line.
        l2o.ar_valid = 1'b1;
        l2o.ar_bits.addr = 48'h18;
        l2o.ar_bits.size = 3'd3;
        l2o.ar_id = 5'd9;
        tick();
        l2o.ar_valid = 1'b0;
        chk("t3_ar_len", msto.ar_bits.len, 8'd0);
        chk("t3_ar_size", msto.ar_bits.size, 3'd3);
        bus_read({192'd0, 64'hDEAD_BEEF_0123_4567}, 8'h00, 1, lat);
        chk("t3_r_data", l2i.r_data, {4{64'hDEAD_BEEF_0123_4567}});
        l2_r_ack();

        // 3b. Narrow write sends only slice 2.
        l2o.aw_valid = 1'b1;
        l2o.aw_bits.addr = 48'h10;
        l2o.aw_bits.size = 3'd3;
        l2o.w_data = wline;
        l2o.w_strb = 32'h0A5A_3C0F;
        tick();
        l2o.aw_valid = 1'b0;
        chk("t3_aw_len", msto.aw_bits.len, 8'd0);
        bus_write(2'd0, wd, ws, wl, nw);
        chk("t3_nbeats", nw, 1);
        chk("t3_w_data", wd[63:0], 64'h3030_3030_3030_3030);
        chk("t3_w_strb", ws[7:0], 8'h5A);
        chk("t3_w_last", wl, 4'b0001);
        l2_b_ack();

        // 4. AW wins over a simultaneous AR; the read waits for the B handshake.
        l2o.ar_valid = 1'b1;
        l2o.ar_bits.addr = 48'h100;
        l2o.ar_bits.size = 3'd5;
        l2o.ar_id = 5'd2;
        l2o.aw_valid = 1'b1;
        l2o.aw_bits.addr = 48'h200;
        l2o.aw_bits.size = 3'd5;
        l2o.aw_id = 5'd4;
        l2o.w_strb = 32'hFFFF_FFFF;
        #1;
        chk("t4_aw_w_ready", {l2i.aw_ready, l2i.w_ready}, 2'b11);
        chk("t4_ar_ready", l2i.ar_ready, 1'b0);
        tick();
        l2o.aw_valid = 1'b0;
        chk("t4_bus_aw_only", {msto.aw_valid, msto.ar_valid}, 2'b10);
        bus_write(2'd0, wd, ws, wl, nw);
        chk("t4_b_id", l2i.b_id, 5'd4);
        chk("t4_ar_blocked", l2i.ar_ready, 1'b0);
        l2_b_ack();
        chk("t4_ar_ready_after_b", l2i.ar_ready, 1'b1);
        tick();
        l2o.ar_valid = 1'b0;
        chk("t4_bus_ar", msto.ar_valid, 1'b1);
        bus_read({4{64'h5555_6666_7777_8888}}, 8'h00, 4, lat);
        chk("t4_r_id", l2i.r_id, 5'd2);
        chk("t4_r_data", l2i.r_data, {4{64'h5555_6666_7777_8888}});
        l2_r_ack();

        // 5. Beat 1 SLVERR, beat 3 DECERR: first error sticks.
        l2o.ar_valid = 1'b1;
        l2o.ar_bits.addr = 48'h40;
        l2o.ar_bits.size = 3'd5;
        l2o.ar_id = 5'd1;
        tick();
        l2o.ar_valid = 1'b0;
        bus_read({4{64'h0}}, 8'hC8, 4, lat);
        chk("t5_r_resp", l2i.r_resp, 2'd2);
        l2_r_ack();
`ifdef L2_AXI_SERDES_ERRCNT_EN
        chk("t5_err_cnt", err_cnt, 16'd1);
`endif

        // 6. Reset during beat 2 abandons the burst.
        l2o.ar_valid = 1'b1;
        l2o.ar_bits.addr = 48'h60;
        l2o.ar_bits.size = 3'd5;
        l2o.ar_id = 5'd6;
        tick();
        l2o.ar_valid = 1'b0;
        msti.ar_ready = 1'b1;
        tick();
        msti = '0;
        msti.r_valid = 1'b1;
        msti.r_data = 64'hAAAA_0000_0000_0000;
        tick();
        msti.r_data = 64'hAAAA_0000_0000_0001;
        tick();
        msti.r_data = 64'hAAAA_0000_0000_0002;
        nrst = 1'b0;
        tick();
        chk("t6_r_ready", msto.r_ready, 1'b0);
        chk("t6_l2i_zero", l2i, '0);
        chk("t6_msto_vr", {msto.ar_valid, msto.aw_valid, msto.w_valid, msto.b_ready}, 4'd0);
`ifdef L2_AXI_SERDES_ERRCNT_EN
        chk("t6_err_cnt", err_cnt, 16'd0);
`endif
        msti = '0;
        nrst = 1'b1;
        tick();
        l2o.ar_valid = 1'b1;
        l2o.ar_bits.addr = 48'h80;
        l2o.ar_id = 5'd8;
        #1;
        chk("t6_ar_ready", l2i.ar_ready, 1'b1);
        tick();
        l2o.ar_valid = 1'b0;
        bus_read({64'hD4, 64'hC3, 64'hB2, 64'hA1}, 8'h00, 4, lat);
        chk("t6_latency", lat, 7);
        chk("t6_r_data", l2i.r_data, {64'hD4, 64'hC3, 64'hB2, 64'hA1});
        chk("t6_r_id", l2i.r_id, 5'd8);
        l2_r_ack();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
